// File: rtl/dice_pkg.sv
`default_nettype none
// ============================================================================
// dice_pkg : shared state encoding and parameter defaults for the roll path
// Revision : 1.0
// ============================================================================
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    SLOW = 2'd2,
    SHOW = 2'd3
  } dice_state_e;

  localparam int DEB_CYCLES_DEF = 16;
  localparam int FAST_DIV_DEF   = 4;
  localparam int SLOW_STEPS_DEF = 8;

  // Counter width that never collapses to zero bits for tiny parameter sets.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce : 2-flop synchroniser followed by a stable-level debouncer
// Revision     : 1.0
// ============================================================================
module btn_debounce
  import dice_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN,
  output logic btn_db
);

  localparam int CNT_W = clog2_min1(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync_meta;
  logic             r_btn_s;
  logic             r_btn_db;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sync_meta <= 1'b0;
      r_btn_s     <= 1'b0;
    end else begin
      r_sync_meta <= BTN;
      r_btn_s     <= r_sync_meta;
    end
  end

  // The level is accepted on the edge the count would reach DEB_CYCLES.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt    <= '0;
      r_btn_db <= 1'b0;
    end else if (r_btn_s == r_btn_db) begin
      r_cnt    <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt    <= '0;
      r_btn_db <= r_btn_s;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign btn_db = r_btn_db;

endmodule
`default_nettype wire

// File: rtl/dice_roll_ctrl.sv
`default_nettype none
// ============================================================================
// dice_roll_ctrl : roll controller producing the dice counter enable pulses
// Revision       : 1.0
// ============================================================================
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int FAST_DIV   = FAST_DIV_DEF,
  parameter int SLOW_STEPS = SLOW_STEPS_DEF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN,
  output logic ROLL_EN,
  output logic ROLLING,
  output logic DONE
);

  localparam int TICK_W = clog2_min1(FAST_DIV * (SLOW_STEPS + 1));
  localparam int STEP_W = clog2_min1(SLOW_STEPS + 1);

  localparam logic [1:0] c_st_idle = 2'(IDLE);
  localparam logic [1:0] c_st_spin = 2'(SPIN);
  localparam logic [1:0] c_st_slow = 2'(SLOW);
  localparam logic [1:0] c_st_show = 2'(SHOW);

  localparam logic [TICK_W-1:0] c_spin_last = TICK_W'(FAST_DIV - 1);
  localparam logic [STEP_W-1:0] c_step_last = STEP_W'(SLOW_STEPS - 1);

  logic              w_btn_db;
  logic              r_btn_db_q;
  logic              w_rise;
  logic              w_fall;
  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [TICK_W-1:0] r_tick;
  logic [STEP_W-1:0] r_step;
  logic [TICK_W-1:0] w_slow_tick_last;
  logic              w_spin_pulse;
  logic              w_slow_pulse;
  logic              w_slow_final;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .CLK    (CLK),
    .RESET  (RESET),
    .BTN    (BTN),
    .btn_db (w_btn_db)
  );

  assign w_rise = w_btn_db & ~r_btn_db_q;
  assign w_fall = ~w_btn_db & r_btn_db_q;

  // Slow step k = r_step + 1 lasts FAST_DIV*(k+1) cycles.
  assign w_slow_tick_last = TICK_W'(FAST_DIV * (int'(r_step) + 2) - 1);

  assign w_spin_pulse = (r_state == c_st_spin) && (r_tick == c_spin_last);
  assign w_slow_pulse = (r_state == c_st_slow) && (r_tick == w_slow_tick_last);
  assign w_slow_final = w_slow_pulse && (r_step == c_step_last);

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle: if (w_rise) w_next = c_st_spin;
      c_st_spin: if (w_fall) w_next = c_st_slow;
      c_st_slow: begin
        // A fresh press wins over finishing the slow-down.
        if (w_rise)            w_next = c_st_spin;
        else if (w_slow_final) w_next = c_st_show;
      end
      c_st_show: if (w_rise) w_next = c_st_spin;
      default:   w_next = c_st_idle;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= c_st_idle;
      r_btn_db_q <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_btn_db_q <= w_btn_db;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tick <= '0;
      r_step <= '0;
    end else if (w_next != r_state) begin
      r_tick <= '0;
      r_step <= '0;
    end else begin
      case (r_state)
        c_st_spin: r_tick <= w_spin_pulse ? '0 : r_tick + 1'b1;
        c_st_slow: begin
          if (w_slow_pulse) begin
            r_tick <= '0;
            r_step <= r_step + 1'b1;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        default: begin
          r_tick <= '0;
          r_step <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ROLL_EN <= 1'b0;
      ROLLING <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      ROLL_EN <= w_spin_pulse | w_slow_pulse;
      ROLLING <= (w_next == c_st_spin) || (w_next == c_st_slow);
      DONE    <= (w_next == c_st_show);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dice_roll_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dice_roll_ctrl : directed bench for dice_roll_ctrl (DEB=4, DIV=4, STEPS=3)
// Revision          : 1.0
// ============================================================================
module tb_dice_roll_ctrl;

  logic CLK = 1'b0;
  logic RESET;
  logic BTN;
  logic ROLL_EN;
  logic ROLLING;
  logic DONE;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  dice_roll_ctrl #(
    .DEB_CYCLES (4),
    .FAST_DIV   (4),
    .SLOW_STEPS (3)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .BTN     (BTN),
    .ROLL_EN (ROLL_EN),
    .ROLLING (ROLLING),
    .DONE    (DONE)
  );

  task automatic check(input string tag, input int c, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc %0d: observed %b expected %b", tag, c, obs, exp);
    end
  endtask

  // Advance one clock and compare {ROLL_EN, ROLLING, DONE} at the falling edge.
  task automatic adv(input string tag, input int c, input bit en, input bit roll, input bit done);
    @(posedge CLK);
    @(negedge CLK);
    check(tag, c, {ROLL_EN, ROLLING, DONE}, {en, roll, done});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    BTN   = 1'b0;
    #23;
    check("reset_out", 0, {ROLL_EN, ROLLING, DONE}, 3'b000);
    check("reset_state", 0, {1'b0, dut.r_state}, 3'd0);
    @(negedge CLK);
    RESET = 1'b0;
    for (int c = 1; c <= 20; c++) adv("idle_hold", c, 1'b0, 1'b0, 1'b0);

    // Short press in IDLE must be ignored.
    BTN = 1'b1;
    for (int c = 1; c <= 3; c++) adv("glitch_idle", c, 1'b0, 1'b0, 1'b0);
    BTN = 1'b0;
    for (int c = 4; c <= 15; c++) adv("glitch_idle", c, 1'b0, 1'b0, 1'b0);
    check("glitch_idle_state", 15, {1'b0, dut.r_state}, 3'd0);

    // Spin, with a 3-cycle release glitch in the middle.
    BTN = 1'b1;
    for (int c = 1; c <= 41; c++) begin
      adv("spin", c, (c >= 11) && ((c - 11) % 4 == 0), c >= 7, 1'b0);
      if (c == 20) BTN = 1'b0;
      if (c == 23) BTN = 1'b1;
    end
    check("spin_state", 41, {1'b0, dut.r_state}, 3'd1);

    // Release: SPIN continues until SLOW entry 7 cycles later.
    BTN = 1'b0;
    for (int c = 42; c <= 48; c++) adv("release", c, (c - 11) % 4 == 0, 1'b1, 1'b0);
    check("slow_state", 48, {1'b0, dut.r_state}, 3'd2);

    // Slow-down: pulses at +8, +20, +36; DONE on the last one.
    for (int r = 1; r <= 36; r++)
      adv("slow", r, (r == 8) || (r == 20) || (r == 36), r < 36, r == 36);
    for (int c = 1; c <= 20; c++) adv("show_hold", c, 1'b0, 1'b0, 1'b1);

    // SHOW -> SPIN on a new press.
    BTN = 1'b1;
    for (int c = 1; c <= 21; c++)
      adv("reroll", c, (c >= 11) && ((c - 11) % 4 == 0), c >= 7, c < 7);
    BTN = 1'b0;
    for (int c = 22; c <= 28; c++) adv("rerelease", c, (c - 11) % 4 == 0, 1'b1, 1'b0);

    // Press again 10 cycles into SLOW: back to 4-cycle spinning, no DONE.
    for (int r = 1; r <= 10; r++) adv("slow2", r, r == 8, 1'b1, 1'b0);
    BTN = 1'b1;
    for (int r = 11; r <= 40; r++)
      adv("restart", r, (r >= 21) && ((r - 21) % 4 == 0), 1'b1, 1'b0);
    check("restart_state", 40, {1'b0, dut.r_state}, 3'd1);

    // Asynchronous reset between edges while spinning.
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check("async_reset_out", 0, {ROLL_EN, ROLLING, DONE}, 3'b000);
    check("async_reset_state", 0, {1'b0, dut.r_state}, 3'd0);
    @(negedge CLK);
    RESET = 1'b0;
    for (int c = 1; c <= 12; c++) adv("post_reset", c, c == 11, c >= 7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
